// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for a 5-stage pipeline: drives latch enables, bubbles,
// PC load/select and sticky halt, and keeps saturating stall/flush perf counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             dREN_ex,
  input  logic [4:0]       rt_ex,
  input  logic             jump_ex,
  input  logic             dREN_mem,
  input  logic             dWEN_mem,
  input  logic             br_taken_mem,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             en_1,
  output logic             en_2,
  output logic             en_3,
  output logic             en_4,
  output logic             flush_1,
  output logic             flush_2,
  output logic             flush_3,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;

  state_t             state_q, state_d;
  logic               halt_q, halt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               memop;
  logic               load_use;
  logic               advance;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign memop    = dREN_mem | dWEN_mem;
  assign load_use = dREN_ex && (rt_ex != 5'd0) && ((rt_ex == rs_id) || (rt_ex == rt_id));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= RUN;
      halt_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      halt_q      <= halt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (halt_wb)             state_d = HALTED;
        else if (memop && !dhit) state_d = DWAIT;
      end
      DWAIT:   if (dhit) state_d = RUN;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // The pipeline advances only when neither halt nor an outstanding dmem access freezes it.
  always_comb begin
    case (state_q)
      RUN:     advance = !halt_wb && !(memop && !dhit);
      DWAIT:   advance = dhit;
      default: advance = 1'b0;
    endcase
  end

  always_comb begin
    pc_en   = 1'b0;
    pc_sel  = 2'd0;
    en_1    = 1'b0;
    en_2    = 1'b0;
    en_3    = 1'b0;
    en_4    = 1'b0;
    flush_1 = 1'b0;
    flush_2 = 1'b0;
    flush_3 = 1'b0;
    if (!RST && advance) begin
      pc_en = 1'b1;
      en_1  = 1'b1;
      en_2  = 1'b1;
      en_3  = 1'b1;
      en_4  = 1'b1;
      if (br_taken_mem) begin
        flush_1 = 1'b1;
        flush_2 = 1'b1;
        flush_3 = 1'b1;
        pc_sel  = 2'd2;
      end else if (jump_ex) begin
        flush_1 = 1'b1;
        flush_2 = 1'b1;
        pc_sel  = 2'd1;
      end else if (load_use) begin
        pc_en   = 1'b0;
        en_1    = 1'b0;
        flush_2 = 1'b1;
      end else if (!ihit) begin
        pc_en   = 1'b0;
        flush_1 = 1'b1;
      end
    end
  end

  always_comb begin
    halt_d      = halt_q | (state_d == HALTED);
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en && (state_d != HALTED)) stall_cnt_d = sat_inc(stall_cnt_q);
    if (flush_1 || flush_2 || flush_3) flush_cnt_d = sat_inc(flush_cnt_q);
  end

  assign halt      = halt_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios plus random traffic
// against a rule-level reference model; counters narrowed to exercise saturation.
module tb_pipeline_hazard_ctrl;

  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          ihit = 1'b1, dhit = 1'b0;
  logic [4:0]    rs_id = '0, rt_id = '0, rt_ex = '0;
  logic          dREN_ex = 1'b0, jump_ex = 1'b0, dREN_mem = 1'b0, dWEN_mem = 1'b0;
  logic          br_taken_mem = 1'b0, halt_wb = 1'b0;
  logic          pc_en, en_1, en_2, en_3, en_4, flush_1, flush_2, flush_3, halt;
  logic [1:0]    pc_sel;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .rs_id(rs_id), .rt_id(rt_id),
    .dREN_ex(dREN_ex), .rt_ex(rt_ex), .jump_ex(jump_ex), .dREN_mem(dREN_mem),
    .dWEN_mem(dWEN_mem), .br_taken_mem(br_taken_mem), .halt_wb(halt_wb),
    .pc_en(pc_en), .pc_sel(pc_sel), .en_1(en_1), .en_2(en_2), .en_3(en_3), .en_4(en_4),
    .flush_1(flush_1), .flush_2(flush_2), .flush_3(flush_3), .halt(halt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic rst, ihit, dhit;
    logic [4:0] rs, rt;
    logic dren_ex;
    logic [4:0] rt_ex;
    logic jump, dren_mem, dwen_mem, br, halt_wb;
  } stim_t;

  typedef struct packed {
    logic [3:0] en;
    logic [2:0] fl;
    logic pc_en;
    logic [1:0] pc_sel;
    logic halt;
    logic [CW-1:0] sc, fc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_bad = 0;
  bit   m_halted = 0, m_wait = 0;
  int   m_sc = 0, m_fc = 0;

  task automatic chk(input string nm, input logic [9:0] got, input logic [9:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, want);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ctrl{en4..1,fl3..1,pc_en,pc_sel}",
          {en_4, en_3, en_2, en_1, flush_3, flush_2, flush_1, pc_en, pc_sel},
          {e.en, e.fl, e.pc_en, e.pc_sel});
      chk("halt", {9'd0, halt}, {9'd0, e.halt});
      chk("stall_cnt", {6'd0, stall_cnt}, {6'd0, e.sc});
      chk("flush_cnt", {6'd0, flush_cnt}, {6'd0, e.fc});
    end
  end

  // Drive one cycle and push what the pipeline rules say the controller must show.
  task automatic apply(input stim_t s);
    exp_t e;
    bit go, lu, memop, nxt_halt;
    @(posedge CLK); #1;
    RST = s.rst; ihit = s.ihit; dhit = s.dhit; rs_id = s.rs; rt_id = s.rt;
    dREN_ex = s.dren_ex; rt_ex = s.rt_ex; jump_ex = s.jump; dREN_mem = s.dren_mem;
    dWEN_mem = s.dwen_mem; br_taken_mem = s.br; halt_wb = s.halt_wb;
    e = '0;
    if (s.rst) begin
      m_halted = 0; m_wait = 0; m_sc = 0; m_fc = 0;
      sb.push_back(e);
      return;
    end
    memop = s.dren_mem | s.dwen_mem;
    lu = s.dren_ex && s.rt_ex != 0 && (s.rt_ex == s.rs || s.rt_ex == s.rt);
    if (m_halted)    go = 0;
    else if (m_wait) go = s.dhit;
    else             go = !s.halt_wb && !(memop && !s.dhit);
    if (go) begin
      e.en = 4'hf; e.pc_en = 1;
      if (s.br)        begin e.fl = 3'b111; e.pc_sel = 2; end
      else if (s.jump) begin e.fl = 3'b011; e.pc_sel = 1; end
      else if (lu)     begin e.pc_en = 0; e.en[0] = 0; e.fl = 3'b010; end
      else if (!s.ihit) begin e.pc_en = 0; e.fl = 3'b001; end
    end
    e.halt = m_halted; e.sc = CW'(m_sc); e.fc = CW'(m_fc);
    sb.push_back(e);
    nxt_halt = m_halted || (!m_wait && s.halt_wb);
    if (!m_halted) begin
      if (m_wait) m_wait = !s.dhit;
      else if (!s.halt_wb && memop && !s.dhit) m_wait = 1;
    end
    if (!e.pc_en && !nxt_halt && m_sc < SAT) m_sc++;
    if (e.fl != 0 && m_fc < SAT) m_fc++;
    m_halted = nxt_halt;
  endtask

  function automatic stim_t idle();
    stim_t s = '0;
    s.ihit = 1;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s = idle();
    s.ihit     = ($urandom_range(0, 3) != 0);
    s.dhit     = $urandom_range(0, 1);
    s.rs       = 5'($urandom_range(0, 3));
    s.rt       = 5'($urandom_range(0, 3));
    s.rt_ex    = 5'($urandom_range(0, 3));
    s.dren_ex  = $urandom_range(0, 1);
    s.jump     = ($urandom_range(0, 7) == 0);
    s.br       = ($urandom_range(0, 7) == 0);
    s.dren_mem = ($urandom_range(0, 4) == 0);
    s.dwen_mem = ($urandom_range(0, 4) == 0);
    s.halt_wb  = ($urandom_range(0, 99) == 0);
    s.rst      = ($urandom_range(0, 149) == 0);
    return s;
  endfunction

  initial begin
    stim_t s;
    s = idle(); s.rst = 1;
    apply(s); apply(s);
    // Load-use on rt=2, then a clean cycle.
    s = idle(); s.dren_ex = 1; s.rt_ex = 2; s.rs = 2; s.rt = 4; apply(s);
    apply(idle());
    s = idle(); s.dren_ex = 1; s.rt_ex = 0; s.rs = 0; s.rt = 0; apply(s);
    // Store in MEM waiting three cycles on dmem.
    s = idle(); s.dwen_mem = 1;
    repeat (3) apply(s);
    s.dhit = 1; apply(s);
    apply(idle());
    s = idle(); s.br = 1; s.dren_ex = 1; s.rt_ex = 3; s.rt = 3; apply(s);
    s = idle(); s.jump = 1; s.ihit = 0; apply(s);
    s = idle(); s.ihit = 0; apply(s);
    s = idle(); s.dren_mem = 1; s.dhit = 1; s.ihit = 0; apply(s);
    repeat (60) apply(rnd());
    // Sticky halt, then reset out of it.
    s = idle(); s.halt_wb = 1; apply(s);
    repeat (4) apply(rnd());
    s = idle(); s.rst = 1; apply(s);
    // Reset while waiting on dmem; the late dhit must not matter.
    s = idle(); s.dren_mem = 1; apply(s); apply(s);
    s.rst = 1; apply(s);
    s = idle(); s.dhit = 1; apply(s);
    apply(idle());
    for (int r = 0; r < 4; r++) begin
      repeat (300) apply(rnd());
      s = idle(); s.rst = 1; apply(s);
    end
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge CLK);
    if (sb.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
